// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: the prediction
// record carried down the D/E pipeline and the PC arithmetic constants.
package branch_resolve_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  // One prediction record: what the predictor said about the instruction at pc.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_bta;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolve_unit_pred_stage_reg.sv
// Single pipeline register for a prediction record with reset, flush and stall.
// Priority: reset > flush > stall > load. A flush clears valid and the
// prediction fields; the PC field keeps following the incoming record.
module pred_stage_reg
  import branch_resolve_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      stall_i,
  input  logic      flush_i,
  input  pred_rec_t rec_i,
  output pred_rec_t rec_o
);

  pred_rec_t rec_q;

  // Record register: reset wins, then flush (overrides stall), then hold on stall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rec_q.valid      <= 1'b0;
      rec_q.pc         <= RESET_PC;
      rec_q.pred_taken <= 1'b0;
      rec_q.pred_bta   <= '0;
    end else if (flush_i) begin
      rec_q.valid      <= 1'b0;
      rec_q.pc         <= rec_i.pc;
      rec_q.pred_taken <= 1'b0;
      rec_q.pred_bta   <= '0;
    end else if (!stall_i) begin
      rec_q <= rec_i;
    end
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries the fetch-time prediction through D and E,
// compares it with the resolved outcome in E, produces the redirect PC and
// the predictor update strobe, and keeps saturating branch/mispredict counts.
// There is no valid/ready handshake here: UpdateEnE and MispredictE are
// single-cycle strobes valid in the cycle the instruction sits in E, and the
// consumer must take them in that cycle (no backpressure is possible).
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int              CNT_WIDTH = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [XLEN-1:0]      PCF,
  input  logic                 PredictedTakenF,
  input  logic [XLEN-1:0]      PredictedBTAF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 FlushE,
  input  logic                 IsBranchE,
  input  logic                 ActualTakenE,
  input  logic [XLEN-1:0]      ActualBTAE,
  output logic [XLEN-1:0]      PCE,
  output logic                 MispredictE,
  output logic [XLEN-1:0]      RedirectPCE,
  output logic                 UpdateEnE,
  output logic [CNT_WIDTH-1:0] BranchCount,
  output logic [CNT_WIDTH-1:0] MispredictCount
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  pred_rec_t rec_f;
  pred_rec_t rec_d;
  pred_rec_t rec_e;
  logic      mispredict;
  logic      flush_d;
  logic      flush_e;

  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] mispred_cnt_q;

  // Every fetch cycle produces a valid record.
  always_comb begin
    rec_f.valid      = 1'b1;
    rec_f.pc         = PCF;
    rec_f.pred_taken = PredictedTakenF;
    rec_f.pred_bta   = PredictedBTAF;
  end

  // A mispredict in E squashes both younger stages; ORing keeps one clear.
  assign flush_d = FlushD | mispredict;
  assign flush_e = FlushE | mispredict;

  pred_stage_reg #(.RESET_PC(RESET_PC)) u_stage_d (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .stall_i (StallD),
    .flush_i (flush_d),
    .rec_i   (rec_f),
    .rec_o   (rec_d)
  );

  // E never stalls; bubbles only come from flushes.
  pred_stage_reg #(.RESET_PC(RESET_PC)) u_stage_e (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .stall_i (1'b0),
    .flush_i (flush_e),
    .rec_i   (rec_d),
    .rec_o   (rec_e)
  );

  // Mispredict: wrong direction, wrong target on a taken branch, or the
  // predictor claiming "taken" for a non-branch. Bubbles never mispredict.
  always_comb begin
    mispredict = 1'b0;
    if (rec_e.valid) begin
      if (IsBranchE) begin
        mispredict = (rec_e.pred_taken != ActualTakenE) |
                     (rec_e.pred_taken & ActualTakenE & (rec_e.pred_bta != ActualBTAE));
      end else begin
        mispredict = rec_e.pred_taken;
      end
    end
  end

  // Correct next PC, only driven when a redirect is actually needed.
  always_comb begin
    RedirectPCE = '0;
    if (mispredict) begin
      if (IsBranchE && ActualTakenE) RedirectPCE = ActualBTAE;
      else                           RedirectPCE = rec_e.pc + PC_INC;
    end
  end

  // Saturating statistics counters; reset takes priority over any increment.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (UpdateEnE && (branch_cnt_q != '1))  branch_cnt_q  <= branch_cnt_q + CNT_ONE;
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + CNT_ONE;
    end
  end

  assign PCE             = rec_e.pc;
  assign MispredictE     = mispredict;
  assign UpdateEnE       = IsBranchE & rec_e.valid;
  assign BranchCount     = branch_cnt_q;
  assign MispredictCount = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vectors, scoreboard queue of
// expected E-stage responses, a negedge monitor, and direct counter checks.
module tb_branch_resolve_unit;

  localparam int          CW     = 4;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] FILL   = 32'h0000_0F00;
  localparam int          CMAX   = 15;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   PCF;
  logic          PredictedTakenF;
  logic [31:0]   PredictedBTAF;
  logic          StallD, FlushD, FlushE;
  logic          IsBranchE, ActualTakenE;
  logic [31:0]   ActualBTAE;
  logic [31:0]   PCE;
  logic          MispredictE;
  logic [31:0]   RedirectPCE;
  logic          UpdateEnE;
  logic [CW-1:0] BranchCount, MispredictCount;

  int checks = 0;
  int errors = 0;
  int exp_bc = 0;
  int exp_mc = 0;

  // {mispredict, update, pce, redirect}
  logic [65:0] exp_q[$];

  branch_resolve_unit #(.CNT_WIDTH(CW), .RESET_PC(RST_PC)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .PCF             (PCF),
    .PredictedTakenF (PredictedTakenF),
    .PredictedBTAF   (PredictedBTAF),
    .StallD          (StallD),
    .FlushD          (FlushD),
    .FlushE          (FlushE),
    .IsBranchE       (IsBranchE),
    .ActualTakenE    (ActualTakenE),
    .ActualBTAE      (ActualBTAE),
    .PCE             (PCE),
    .MispredictE     (MispredictE),
    .RedirectPCE     (RedirectPCE),
    .UpdateEnE       (UpdateEnE),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: whenever E presents a strobe, pop and compare one expected record.
  always @(negedge CLK) begin
    if (MispredictE || UpdateEnE) begin
      logic [65:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: mp=%b upd=%b pce=%h rd=%h with empty queue",
                 MispredictE, UpdateEnE, PCE, RedirectPCE);
      end else begin
        e = exp_q.pop_front();
        if ({MispredictE, UpdateEnE, PCE, RedirectPCE} !== e)
          begin
            errors++;
            $display("FAIL e_stage: got mp=%b upd=%b pce=%h rd=%h expected mp=%b upd=%b pce=%h rd=%h",
                     MispredictE, UpdateEnE, PCE, RedirectPCE, e[65], e[64], e[63:32], e[31:0]);
          end
      end
    end
  end

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Driver: fetch one prediction, resolve it two cycles later in E.
  // Called just after a posedge; returns just after the edge that consumes E.
  task automatic send(input logic [31:0] pc, input logic pt, input logic [31:0] bta,
                      input logic isb, input logic at, input logic [31:0] abta,
                      input logic fe, input logic exp_mp, input logic [31:0] exp_rd);
    PCF = pc; PredictedTakenF = pt; PredictedBTAF = bta;
    @(posedge CLK); #1;
    PCF = FILL; PredictedTakenF = 1'b0; PredictedBTAF = '0;
    @(posedge CLK); #1;
    IsBranchE = isb; ActualTakenE = at; ActualBTAE = abta; FlushE = fe;
    if (exp_mp || isb) exp_q.push_back({exp_mp, isb, pc, exp_rd});
    if (isb)    exp_bc = sat_inc(exp_bc);
    if (exp_mp) exp_mc = sat_inc(exp_mc);
    @(posedge CLK); #1;
    IsBranchE = 1'b0; ActualTakenE = 1'b0; ActualBTAE = '0; FlushE = 1'b0;
    chk("branch_count", 32'(BranchCount), 32'(exp_bc));
    chk("mispredict_count", 32'(MispredictCount), 32'(exp_mc));
  endtask

  // After a mispredict edge: E and then the cleared D must show as bubbles.
  task automatic check_bubbles();
    IsBranchE = 1'b1;
    chk("bubble_e_valid", 32'(UpdateEnE), 32'd0);
    @(posedge CLK); #1;
    chk("bubble_d_valid", 32'(UpdateEnE), 32'd0);
    IsBranchE = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; PCF = FILL; PredictedTakenF = 1'b0; PredictedBTAF = '0;
    StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
    IsBranchE = 1'b0; ActualTakenE = 1'b0; ActualBTAE = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    // Reset state
    chk("rst_pce", PCE, RST_PC);
    chk("rst_mispredict", 32'(MispredictE), 32'd0);
    chk("rst_redirect", RedirectPCE, 32'd0);
    chk("rst_update", 32'(UpdateEnE), 32'd0);
    chk("rst_branch_count", 32'(BranchCount), 32'd0);
    chk("rst_mispredict_count", 32'(MispredictCount), 32'd0);

    // Correct not-taken
    send(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    // Direction mispredict, then both stages must be bubbles
    send(32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h400, 1'b0, 1'b1, 32'h400);
    check_bubbles();
    @(posedge CLK); #1;
    // Target mispredict
    send(32'h300, 1'b1, 32'h300, 1'b1, 1'b1, 32'h340, 1'b0, 1'b1, 32'h340);
    // Correct taken
    send(32'h500, 1'b1, 32'h600, 1'b1, 1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
    // Alias on a non-branch at the top of the address space (PC+4 wraps)
    send(32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    // Predicted taken, actually not taken: fall through
    send(32'h700, 1'b1, 32'h800, 1'b1, 1'b0, 32'h800, 1'b0, 1'b1, 32'h704);
    // FlushE coincident with mispredict: one clear, one count
    send(32'h740, 1'b0, 32'h0, 1'b1, 1'b1, 32'h780, 1'b1, 1'b1, 32'h780);
    check_bubbles();
    @(posedge CLK); #1;

    // StallD alone holds D
    PCF = 32'h900;
    @(posedge CLK); #1;
    StallD = 1'b1; PCF = 32'h904;
    @(posedge CLK); #1;
    chk("stall_pce_1", PCE, 32'h900);
    @(posedge CLK); #1;
    chk("stall_pce_2", PCE, 32'h900);
    StallD = 1'b0; PCF = FILL;
    @(posedge CLK); #1;
    chk("stall_pce_3", PCE, 32'h900);
    @(posedge CLK); #1;
    chk("stall_release_pce", PCE, FILL);

    // StallD together with FlushD: flush wins, D is cleared
    StallD = 1'b1; FlushD = 1'b1;
    @(posedge CLK); #1;
    StallD = 1'b0; FlushD = 1'b0;
    @(posedge CLK); #1;
    IsBranchE = 1'b1;
    chk("stall_flush_d", 32'(UpdateEnE), 32'd0);
    IsBranchE = 1'b0;
    @(posedge CLK); #1;

    // Saturation of both counters
    for (int i = 0; i < 20; i++)
      send(32'h2000 + 32'(i) * 32'd16, 1'b1, 32'h3000, 1'b0, 1'b0, 32'h0,
           1'b0, 1'b1, 32'h2004 + 32'(i) * 32'd16);
    for (int i = 0; i < 12; i++)
      send(32'h4000 + 32'(i) * 32'd8, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,
           1'b0, 1'b0, 32'h0);
    chk("branch_count_sat", 32'(BranchCount), 32'd15);
    chk("mispredict_count_sat", 32'(MispredictCount), 32'd15);

    // Reset asserted while a mispredict is in E
    PCF = 32'h200;
    @(posedge CLK); #1;
    PCF = FILL;
    @(posedge CLK); #1;
    IsBranchE = 1'b1; ActualTakenE = 1'b1; ActualBTAE = 32'h400; RESET = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 32'h200, 32'h400});
    @(posedge CLK); #1;
    RESET = 1'b0;
    exp_bc = 0; exp_mc = 0;
    chk("mid_rst_pce", PCE, RST_PC);
    chk("mid_rst_mispredict", 32'(MispredictE), 32'd0);
    chk("mid_rst_redirect", RedirectPCE, 32'd0);
    chk("mid_rst_update", 32'(UpdateEnE), 32'd0);
    chk("mid_rst_branch_count", 32'(BranchCount), 32'(exp_bc));
    chk("mid_rst_mispredict_count", 32'(MispredictCount), 32'(exp_mc));
    IsBranchE = 1'b0; ActualTakenE = 1'b0; ActualBTAE = '0;
    repeat (3) @(posedge CLK);
    #1;

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter CNT_WIDTH, default 32, width of the branch and mispredict statistics counters.
REQ-002 Parameter RESET_PC, default 32'h0, value loaded into the carried PC fields on reset.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 PCF  input  32  fetch-stage PC.
REQ-006 PredictedTakenF  input  1  predictor taken bit for PCF.
REQ-007 PredictedBTAF  input  32  predictor target for PCF.
REQ-008 StallD / FlushD / FlushE  input  1 each  hazard-unit stall and flush controls for the D and E stage registers.
REQ-009 IsBranchE  input  1  instruction in E is a branch or jump.
REQ-010 ActualTakenE  input  1  resolved outcome in E.
REQ-011 ActualBTAE  input  32  resolved target in E.
REQ-012 PCE  output  32  PC carried to E; drives the predictor update index.
REQ-013 MispredictE  output  1  combinational: the instruction in E was mispredicted.
REQ-014 RedirectPCE  output  32  combinational: correct next PC when MispredictE=1, else 0.
REQ-015 UpdateEnE  output  1  combinational: IsBranchE & ValidE; predictor update strobe.
REQ-016 BranchCount / MispredictCount  output  CNT_WIDTH each  statistics counters.

Function
REQ-017 The unit SHALL carry {Valid, PC, PredTaken, PredBTA} through a D register and an E register.
REQ-018 The D register SHALL load {1, PCF, PredictedTakenF, PredictedBTAF} each cycle unless it is held or cleared.
REQ-019 The E register SHALL load the D register contents each cycle unless it is cleared.
REQ-020 Flush precedence: a flush SHALL clear Valid, PredTaken and PredBTA in the next cycle and SHALL override a stall.
REQ-021 StallD=1 with no flush SHALL hold the D register unchanged.
REQ-022 The E register SHALL have no stall input; FlushE is the only way to insert a bubble.
REQ-023 MispredictE SHALL be 1 only when ValidE=1 and one of the following holds:
  - IsBranchE=1 and PredTakenE != ActualTakenE;
  - IsBranchE=1, both taken, and PredBTAE != ActualBTAE;
  - IsBranchE=0 and PredTakenE=1 (predictor alias on a non-branch).
REQ-024 RedirectPCE SHALL be ActualBTAE if (IsBranchE & ActualTakenE), else PCE+4, computed modulo 2^32.
REQ-025 When MispredictE=1, the D and E registers SHALL both be cleared at the next edge, as if FlushD and FlushE were both asserted.
REQ-026 The self-flush of REQ-025 SHALL OR with the external flushes; simultaneous assertion SHALL give one clear and no double-count.
REQ-027 BranchCount SHALL increment by 1 on each edge where UpdateEnE=1.
REQ-028 MispredictCount SHALL increment by 1 on each edge where MispredictE=1.
REQ-029 Both counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-030 ValidE=0 SHALL force MispredictE=0 and UpdateEnE=0 regardless of the other E inputs.
REQ-031 Latency: a prediction at PCF in cycle n SHALL appear in E in cycle n+2 when there are no stalls.

Reset
REQ-032 RESET=1 at a posedge SHALL clear ValidD and ValidE.
REQ-033 The same reset SHALL load RESET_PC into the carried PC fields and SHALL clear PredTaken, PredBTA and both counters.
REQ-034 After reset: PCE=RESET_PC, MispredictE=0, RedirectPCE=0, UpdateEnE=0, BranchCount=0, MispredictCount=0.
REQ-035 Reset SHALL take priority over stall, flush and the self-flush, including when asserted mid-mispredict.

Structure
REQ-036 The shared package SHALL define:
  - the prediction-record struct {Valid, PC, PredTaken, PredBTA};
  - the XLEN=32 constant;
  - the PC-increment constant 4.
REQ-037 One sub-module, pred_stage_reg, SHALL implement a single stall/flush/reset record register and SHALL be instantiated for D and E.
REQ-038 The mispredict compare and the counters SHALL reside in the top module.

Verification
REQ-039 Correct not-taken: PCF=0x100 with PredictedTakenF=0; two cycles later IsBranchE=1, ActualTakenE=0 -> MispredictE=0, UpdateEnE=1, BranchCount=1.
REQ-040 Direction mispredict: predicted not-taken at 0x200, actual taken to 0x400 -> MispredictE=1, RedirectPCE=0x400, ValidD=ValidE=0 next cycle, MispredictCount=1.
REQ-041 Target mispredict: predicted taken to 0x300, actual taken to 0x340 -> MispredictE=1, RedirectPCE=0x340.
REQ-042 Alias mispredict: IsBranchE=0, PredTakenE=1, PCE=0xFFFFFFFC -> MispredictE=1, RedirectPCE=0x0 (wrap), UpdateEnE=0.
REQ-043 Hazards: StallD together with FlushD -> D is cleared. FlushE with a mispredict in the same cycle -> single clear, counter +1. With CNT_WIDTH=4 and 20 mispredicts, MispredictCount holds at 15.
REQ-044 Reset during MispredictE=1 -> all outputs at their reset values next cycle and the counters not incremented.
